cdc_tx_handshake: RTL
=====================

# cdc_tx_handshake

Source-domain transmit controller that sits directly upstream of the source-side data register in the CDC path. It accepts bytes from a local producer over a ready/valid interface and buffers them in a small FIFO. It presents one byte at a time to the data register as a level request on `valid_send_o`, and runs a 4-phase req/ack handshake against an acknowledge returned asynchronously from the destination domain. Because the request is held and the byte stays stable until the acknowledge arrives, the destination side can sample the byte safely regardless of the clock ratio.

## Interface
Parameters:
- `DEPTH`, 4, number of FIFO entries; power of two, minimum 2.
- `SYNC_STAGES`, 2, flops in the `ack_async_i` synchronizer; minimum 2.
- `TIMEOUT_CYCLES`, 256, request timeout in `clk_i` cycles; used only with `CDC_TX_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  source-domain clock.
- `resetn_i`  in  1  reset: asynchronous, active-low, on clock `clk_i`.
- `in_data_i`  in  8  producer byte.
- `in_valid_i`  in  1  producer byte valid.
- `in_ready_o`  out  1  FIFO can accept a byte (combinational: `count != DEPTH`).
- `data_o`  out  8  byte driven to the data register; stable while `valid_send_o` is high.
- `valid_send_o`  out  1  handshake request level driven to the data register.
- `ack_async_i`  in  1  destination-domain acknowledge; asynchronous to `clk_i`.
- `sent_o`  out  1  one-cycle pulse when the acknowledge for the current byte is seen.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err_timeout_o`  out  1  sticky timeout flag.

## Operation
- Push: a push occurs on `in_valid_i && in_ready_o`. The byte is written at the write pointer, which advances; pointers wrap modulo `DEPTH`.
- `count` is `$clog2(DEPTH)+1` bits wide and changes by +1 on push only, -1 on pop only, and is unchanged on a simultaneous push and pop.
- Full: when `count == DEPTH`, `in_ready_o` is 0 and no push occurs, even if a pop happens in the same cycle.
- Empty: when `count == 0`, no pop occurs.
- The acknowledge is resynchronized through `SYNC_STAGES` flops, all reset to 0. The output of the last flop is `ack_s`.
- State machine states: IDLE, REQ, RELEASE. Transitions:
  - IDLE, `count != 0` and `ack_s == 0`: pop the head byte, load `data_o`, set `valid_send_o = 1`, go to REQ.
  - REQ, `ack_s == 1`: set `valid_send_o = 0`, pulse `sent_o`, go to RELEASE.
  - RELEASE, `ack_s == 0`: go to IDLE.
- `data_o` changes only on the IDLE→REQ transition.
- Reset values: `data_o = 0`, `valid_send_o = 0`, `sent_o = 0`, `err_timeout_o = 0`, `level_o = 0`, `in_ready_o = 1`, state IDLE, pointers 0.
- Reset mid-operation: the FIFO contents are discarded and `valid_send_o` drops immediately (asynchronous reset). After reset, IDLE waits for `ack_s == 0` before issuing a new request.

## Timing
- Push-to-request latency: a byte pushed at edge t into an empty FIFO in IDLE gives `valid_send_o = 1` after edge t+1.
- Acknowledge latency: if `ack_async_i` rises before edge a, `ack_s = 1` after edge a+SYNC_STAGES-1, and `valid_send_o` falls and `sent_o` pulses after edge a+SYNC_STAGES.
- Back-to-back throughput: at most one byte per full handshake, 2·(SYNC_STAGES+1) cycles plus the destination-side turnaround.
- `level_o` is registered and reflects the push/pop of the previous edge.

## Configuration
- `CDC_TX_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to REQ and increments each cycle spent in REQ.
  - When the counter reaches `TIMEOUT_CYCLES-1` with `ack_s == 0`, `valid_send_o` drops, `err_timeout_o` sets (sticky until reset), no `sent_o` pulse is issued, the byte is lost, and the state machine goes to RELEASE.
- `CDC_TX_TIMEOUT_EN` not defined: no counter is built, `err_timeout_o` is tied to 0, and REQ waits indefinitely.

## Test plan
- Single byte, `SYNC_STAGES = 2`: push 0xA5 with the acknowledge looped back after 3 cycles -> `data_o = 0xA5`, `valid_send_o` high from edge t+1 until 3 edges after the acknowledge rises, one `sent_o` pulse, `level_o` returns to 0.
- Fill: push 5 bytes 0x01..0x05 with `ack_async_i` held at 0 and `DEPTH = 4` -> one byte popped into REQ, the FIFO fills behind it, `in_ready_o` goes low, the 6th byte is refused. Releasing the acknowledge sequence then gives output order 0x01..0x05.
- Simultaneous push/pop at `level_o = 2`: `level_o` stays 2 and the data order is preserved.
- Pointer wrap: stream 12 bytes 0x10..0x1B through `DEPTH = 4` -> all delivered in order, none dropped.
- Reset asserted while in REQ with `level_o = 3`: `valid_send_o = 0` and `level_o = 0` immediately. After release, no request is issued until a new push.
- Timeout (`CDC_TX_TIMEOUT_EN`, `TIMEOUT_CYCLES = 16`, acknowledge never returned): `valid_send_o` falls after 16 cycles in REQ, `err_timeout_o = 1` and stays set, the next byte proceeds normally.

Source files
------------

// File: rtl/cdc_tx_handshake.sv
// cdc_tx_handshake
// Source-domain transmit controller for the CDC data path. Bytes from a local
// producer (ready/valid) are buffered in a small FIFO and presented one at a
// time to the source-side data register. Each byte is held with a level
// request on valid_send_o until the destination acknowledge is seen (4-phase
// req/ack), so the destination can sample it regardless of the clock ratio.
//
// Build option: define CDC_TX_TIMEOUT_EN to add a request timeout. If no
// acknowledge arrives within TIMEOUT_CYCLES cycles, the byte is abandoned and
// err_timeout_o is set. Without the macro, REQ waits forever and
// err_timeout_o is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request out; pops the head byte once ack_s has returned to 0
// REQ     | valid_send_o high, data_o stable, waiting for ack_s == 1
// RELEASE | request withdrawn, waiting for ack_s to fall (phase 4)

module cdc_tx_handshake #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [7:0]               data_o,
  output logic                     valid_send_o,
  input  logic                     ack_async_i,
  output logic                     sent_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     err_timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [1:0]             state_q, state_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   sent_q, sent_d;
  logic                   push;
  logic                   pop;

`ifdef CDC_TX_TIMEOUT_EN
  // Counter only needs to hold TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  // Full blocks the push even when a pop happens on the same edge.
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  assign ack_s      = sync_q[SYNC_STAGES-1];

  assign data_o       = data_q;
  assign valid_send_o = valid_q;
  assign sent_o       = sent_q;
  assign level_o      = count_q;
`ifdef CDC_TX_TIMEOUT_EN
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  // Resynchronize the destination acknowledge; all stages clear on reset so
  // IDLE never sees a stale acknowledge after a reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async_i};
    end
  end

  // FIFO storage; contents are don't-care after reset since the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Handshake sequencing: pop into the output register, hold, release.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    sent_d  = 1'b0;
    pop     = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !ack_s) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = ST_REQ;
`ifdef CDC_TX_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          valid_d = 1'b0;
          sent_d  = 1'b1;
          state_d = ST_RELEASE;
        end else begin
`ifdef CDC_TX_TIMEOUT_EN
          // Abandon the byte; RELEASE still waits for ack_s low before reuse.
          if (tmo_cnt_q == TMO_LAST) begin
            valid_d = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
`endif
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake registers; reset drops the request immediately.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sent_q  <= sent_d;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`endif

endmodule
